// File: rtl/multi_cycle_fsm_controller.sv
// multi_cycle_fsm_controller: multi-cycle MIPS control FSM with memory handshake; CTRL_PERF_CNT_EN adds cycle/instr counters
module multi_cycle_fsm_controller #(
  parameter int STATE_W = 4,
  parameter int ALUCTRL_W = 4,
  parameter int RESET_STATE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 iord,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic                 ir_write,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 pc_en,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [STATE_W-1:0]   state,
  output logic                 instr_done,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0]          cycle_cnt,
  output logic [31:0]          instr_cnt,
  output logic                 illegal_op
`else
  output logic                 illegal_op
`endif
);
  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
    BRANCH, BRNE, ADDIEX, ADDIWB, JUMP, TRAP
  } state_t;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0111);
  state_t st;
  state_t dec_next;
  logic [ALUCTRL_W-1:0] f_alu;
  logic funct_ok;
  logic branch;
  logic branch_ne;
  always_comb begin
    dec_next = TRAP;
    case (op)
      6'b100011, 6'b101011: dec_next = MEMADR;
      6'b000000: dec_next = EXEC;
      6'b000100: dec_next = BRANCH;
      6'b000101: dec_next = BRNE;
      6'b001000: dec_next = ADDIEX;
      6'b000010: dec_next = JUMP;
      default: dec_next = TRAP;
    endcase
  end
  always_comb begin
    f_alu = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: f_alu = ALU_ADD;
      6'b100010: f_alu = ALU_SUB;
      6'b100100: f_alu = ALU_AND;
      6'b100101: f_alu = ALU_OR;
      6'b101010: f_alu = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= state_t'(STATE_W'(RESET_STATE));
      illegal_op <= 1'b0;
    end else begin
      case (st)
        FETCH:  st <= mem_ready ? DECODE : FETCH;
        DECODE: st <= dec_next;
        MEMADR: st <= op == 6'b100011 ? MEMRD : MEMWR;
        MEMRD:  st <= mem_ready ? MEMWB : MEMRD;
        MEMWR:  st <= mem_ready ? FETCH : MEMWR;
        EXEC:   st <= funct_ok ? ALUWB : TRAP;
        ADDIEX: st <= ADDIWB;
        TRAP:   st <= TRAP;
        default: st <= FETCH;
      endcase
      illegal_op <= illegal_op | (st == DECODE && dec_next == TRAP) | (st == EXEC && !funct_ok);
    end
  // Decode is purely from state (plus handshake/zero), so a wait cycle never leaks a write enable.
  always_comb begin
    state = st;
    branch = st == BRANCH;
    branch_ne = st == BRNE;
    iord = st == MEMRD || st == MEMWR;
    alu_src_a = st inside {MEMADR, EXEC, BRANCH, BRNE, ADDIEX};
    alu_src_b = st == FETCH ? 2'b01 : st == DECODE ? 2'b11 : st inside {MEMADR, ADDIEX} ? 2'b10 : 2'b00;
    pc_src = st == JUMP ? 2'b10 : (branch || branch_ne) ? 2'b01 : 2'b00;
    ir_write = st == FETCH && mem_ready;
    mem_write = st == MEMWR;
    reg_write = st inside {MEMWB, ALUWB, ADDIWB};
    reg_dst = st == ALUWB;
    mem_to_reg = st == MEMWB;
    pc_en = ir_write || st == JUMP || (branch && zero) || (branch_ne && !zero);
    alu_control = st inside {FETCH, DECODE, MEMADR, ADDIEX} ? ALU_ADD :
                  (branch || branch_ne) ? ALU_SUB : st == EXEC ? f_alu : '0;
    instr_done = st inside {MEMWB, ALUWB, ADDIWB, BRANCH, BRNE, JUMP} || (st == MEMWR && mem_ready);
  end
`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + (st != TRAP ? 32'd1 : 32'd0);
      instr_cnt <= instr_cnt + {31'd0, instr_done};
    end
`endif
endmodule

// File: tb/tb_multi_cycle_fsm_controller.sv
// tb_multi_cycle_fsm_controller: directed-vector bench for the multi-cycle MIPS control FSM
module tb_multi_cycle_fsm_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_to_reg, reg_dst, iord, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic ir_write, mem_write, reg_write, pc_en;
  logic [3:0] alu_control;
  logic [3:0] state;
  logic instr_done, illegal_op;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  multi_cycle_fsm_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .iord(iord), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .pc_en(pc_en), .alu_control(alu_control), .state(state),
    .instr_done(instr_done),
`ifdef CTRL_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (instr_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0; op = '0; funct = '0; zero = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #2;
    vectors++;
    if (state !== 4'd0 || illegal_op !== 1'b0) begin miscompares++; $display("FAIL reset_state state=%0d illegal=%b exp 0/0", state, illegal_op); end
    vectors++;
    if ({ir_write, mem_write, reg_write, pc_en, instr_done} !== 5'b0) begin miscompares++; $display("FAIL reset_enables got=%b exp=00000", {ir_write, mem_write, reg_write, pc_en, instr_done}); end
    vectors++;
    if (alu_src_b !== 2'b01 || alu_control !== 4'b0010) begin miscompares++; $display("FAIL reset_fetch_dec srcb=%b aluc=%b exp 01/0010", alu_src_b, alu_control); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_rtype_sub();
    int d0;
    op = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
    d0 = done_cnt;
    #1;
    vectors++;
    if (state !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1) begin miscompares++; $display("FAIL rt_fetch state=%0d ir=%b pcen=%b exp 0/1/1", state, ir_write, pc_en); end
    tick();
    vectors++;
    if (state !== 4'd1 || alu_src_b !== 2'b11) begin miscompares++; $display("FAIL rt_decode state=%0d srcb=%b exp 1/11", state, alu_src_b); end
    tick();
    vectors++;
    if (state !== 4'd6 || alu_control !== 4'b0110 || alu_src_a !== 1'b1) begin miscompares++; $display("FAIL rt_exec state=%0d aluc=%b srca=%b exp 6/0110/1", state, alu_control, alu_src_a); end
    tick();
    vectors++;
    if (state !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || instr_done !== 1'b1) begin miscompares++; $display("FAIL rt_aluwb state=%0d rw=%b rd=%b done=%b exp 7/1/1/1", state, reg_write, reg_dst, instr_done); end
    tick();
    vectors++;
    if (state !== 4'd0 || done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rt_done_once state=%0d pulses=%0d exp 0/1", state, done_cnt - d0); end
  endtask

  task automatic test_lw_waits();
    int es[9] = '{0, 0, 0, 1, 2, 3, 3, 3, 4};
    logic mr[9] = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
    logic ei[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    op = 6'b100011;
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr[i];
      #1;
      vectors++;
      if (state !== es[i] || ir_write !== ei[i]) begin miscompares++; $display("FAIL lw_cyc%0d state=%0d ir=%b exp %0d/%b", i, state, ir_write, es[i], ei[i]); end
      if (i != 2 && i != 8 && {mem_write, reg_write} !== 2'b00) begin vectors++; miscompares++; $display("FAIL lw_wait_we cyc%0d got=%b exp=00", i, {mem_write, reg_write}); end
      if (i == 8) begin
        vectors++;
        if (mem_to_reg !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin miscompares++; $display("FAIL lw_memwb m2r=%b rw=%b rd=%b exp 1/1/0", mem_to_reg, reg_write, reg_dst); end
      end
      tick();
    end
    vectors++;
    if (state !== 4'd0) begin miscompares++; $display("FAIL lw_end state=%0d exp 0", state); end
  endtask

  task automatic test_sw_waits();
    int es[7] = '{0, 1, 2, 5, 5, 5, 5};
    logic mr[7] = '{1, 1, 1, 0, 0, 0, 1};
    int mw = 0;
    op = 6'b101011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i];
      #1;
      if (mem_write === 1'b1) mw++;
      vectors++;
      if (state !== es[i] || instr_done !== (i == 6)) begin miscompares++; $display("FAIL sw_cyc%0d state=%0d done=%b exp %0d/%b", i, state, instr_done, es[i], i == 6); end
      tick();
    end
    vectors++;
    if (mw !== 4 || state !== 4'd0) begin miscompares++; $display("FAIL sw_hold mw_cycles=%0d state=%0d exp 4/0", mw, state); end
  endtask

  task automatic test_branches();
    logic [5:0] ops[3] = '{6'b000100, 6'b000101, 6'b000101};
    logic zs[3] = '{1, 1, 0};
    int st_e[3] = '{8, 9, 9};
    logic pe[3] = '{1, 0, 1};
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = ops[i]; zero = zs[i];
      tick(); tick();
      vectors++;
      if (state !== st_e[i] || pc_en !== pe[i] || pc_src !== 2'b01 || alu_control !== 4'b0110 || instr_done !== 1'b1) begin
        miscompares++; $display("FAIL br%0d state=%0d pcen=%b pcsrc=%b aluc=%b done=%b exp %0d/%b/01/0110/1", i, state, pc_en, pc_src, alu_control, instr_done, st_e[i], pe[i]);
      end
      tick();
    end
    zero = 1'b0;
  endtask

  task automatic test_addi();
    op = 6'b001000; mem_ready = 1'b1;
    tick(); tick();
    vectors++;
    if (state !== 4'd10 || alu_src_b !== 2'b10 || alu_src_a !== 1'b1 || reg_write !== 1'b0) begin miscompares++; $display("FAIL addi_ex state=%0d srcb=%b srca=%b rw=%b exp 10/10/1/0", state, alu_src_b, alu_src_a, reg_write); end
    tick();
    vectors++;
    if (state !== 4'd11 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0 || instr_done !== 1'b1) begin miscompares++; $display("FAIL addi_wb state=%0d rw=%b rd=%b m2r=%b done=%b exp 11/1/0/0/1", state, reg_write, reg_dst, mem_to_reg, instr_done); end
    tick();
  endtask

  task automatic test_jump_trap();
    op = 6'b000010; mem_ready = 1'b1;
    tick(); tick();
    vectors++;
    if (state !== 4'd12 || pc_src !== 2'b10 || pc_en !== 1'b1 || instr_done !== 1'b1) begin miscompares++; $display("FAIL jump state=%0d pcsrc=%b pcen=%b done=%b exp 12/10/1/1", state, pc_src, pc_en, instr_done); end
    tick();
    op = 6'b111111;
    tick(); tick();
    vectors++;
    if (state !== 4'd13 || illegal_op !== 1'b1) begin miscompares++; $display("FAIL trap_enter state=%0d illegal=%b exp 13/1", state, illegal_op); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (state !== 4'd13 || {ir_write, mem_write, reg_write, pc_en, instr_done} !== 5'b0) begin miscompares++; $display("FAIL trap_hold%0d state=%0d en=%b exp 13/00000", i, state, {ir_write, mem_write, reg_write, pc_en, instr_done}); end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (state !== 4'd0 || illegal_op !== 1'b0) begin miscompares++; $display("FAIL trap_reset state=%0d illegal=%b exp 0/0", state, illegal_op); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_bad_funct();
    op = 6'b000000; funct = 6'b111111; mem_ready = 1'b1;
    tick(); tick();
    vectors++;
    if (state !== 4'd6 || illegal_op !== 1'b0) begin miscompares++; $display("FAIL badf_exec state=%0d illegal=%b exp 6/0", state, illegal_op); end
    tick();
    vectors++;
    if (state !== 4'd13 || illegal_op !== 1'b1 || reg_write !== 1'b0) begin miscompares++; $display("FAIL badf_trap state=%0d illegal=%b rw=%b exp 13/1/0", state, illegal_op, reg_write); end
    do_reset();
  endtask

  task automatic test_reset_mid_sw();
    op = 6'b101011; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin miscompares++; $display("FAIL mid_sw_pre state=%0d mw=%b exp 5/1", state, mem_write); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin miscompares++; $display("FAIL mid_sw_abort state=%0d mw=%b rw=%b exp 0/0/0", state, mem_write, reg_write); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
`ifdef CTRL_PERF_CNT_EN
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
    repeat (12) tick();
    vectors++;
    if (instr_cnt !== 32'd3 || cycle_cnt !== 32'd12) begin miscompares++; $display("FAIL perf_cnt instr=%0d cycle=%0d exp 3/12", instr_cnt, cycle_cnt); end
`else
    int d0;
    op = 6'b000000; funct = 6'b100101; mem_ready = 1'b1;
    d0 = done_cnt;
    repeat (12) tick();
    vectors++;
    if (done_cnt - d0 !== 3 || state !== 4'd0) begin miscompares++; $display("FAIL b2b pulses=%0d state=%0d exp 3/0", done_cnt - d0, state); end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_lw_waits();
    test_sw_waits();
    test_branches();
    test_addi();
    test_jump_trap();
    test_bad_funct();
    test_reset_mid_sw();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
